// File: rtl/pca_recon.sv
// pca_recon: PCA reconstruction x_hat = W^T * y in 16.16 fixed point on one shared multiplier; define PCA_RECON_ERR_EN for error outputs e = x - x_hat
module pca_recon #(
  parameter int FRAC = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic signed [31:0] y1_in,
  input  logic signed [31:0] y2_in,
  input  logic signed [31:0] w11_in,
  input  logic signed [31:0] w12_in,
  input  logic signed [31:0] w21_in,
  input  logic signed [31:0] w22_in,
`ifdef PCA_RECON_ERR_EN
  input  logic signed [31:0] x1_in,
  input  logic signed [31:0] x2_in,
  output logic signed [31:0] e1_out,
  output logic signed [31:0] e2_out,
`endif
  output logic signed [31:0] xh1_out,
  output logic signed [31:0] xh2_out,
  output logic               out_valid,
  input  logic               out_ready
);

  typedef enum logic [2:0] {IDLE, MUL1, MUL2, MUL3, MUL4, DONE} state_t;

  state_t r_state, w_next;

  logic signed [31:0] r_y1, r_y2, r_w11, r_w12, r_w21, r_w22;
  logic signed [31:0] r_acc, r_p1, r_xh1, r_xh2;
  logic signed [31:0] w_a, w_b;
  logic signed [63:0] w_prod;
  logic signed [31:0] w_term;
`ifdef PCA_RECON_ERR_EN
  logic signed [31:0] r_x1, r_x2, r_e1, r_e2;
`endif

  // Operand steering: y1 pairs with row-1 terms in MUL1/MUL3, y2 with row-2 terms in MUL2/MUL4
  assign w_a    = (r_state == MUL1 || r_state == MUL3) ? r_y1 : r_y2;
  assign w_b    = r_state == MUL1 ? r_w11 :
                  r_state == MUL2 ? r_w21 :
                  r_state == MUL3 ? r_w12 : r_w22;
  assign w_prod = 64'(w_a) * 64'(w_b);
  assign w_term = 32'(w_prod >>> FRAC);

  // State register
  always_ff @(posedge clk or posedge reset)
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;

  // Next-state logic: fixed four-cycle product sequence, handshakes only in IDLE and DONE
  always_comb
    w_next = r_state == IDLE ? (in_valid ? MUL1 : IDLE) :
             r_state == MUL1 ? MUL2 :
             r_state == MUL2 ? MUL3 :
             r_state == MUL3 ? MUL4 :
             r_state == MUL4 ? DONE :
             (out_ready ? IDLE : DONE);

  // Handshake outputs; in_ready is held low for as long as reset is asserted
  always_comb begin
    in_ready  = (r_state == IDLE) && !reset;
    out_valid = r_state == DONE;
  end

  // Datapath: capture operands on accept, accumulate one product per MUL state,
  // and publish both results together so the outputs keep the last result until the next DONE
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_y1  <= '0;
      r_y2  <= '0;
      r_w11 <= '0;
      r_w12 <= '0;
      r_w21 <= '0;
      r_w22 <= '0;
      r_acc <= '0;
      r_p1  <= '0;
      r_xh1 <= '0;
      r_xh2 <= '0;
`ifdef PCA_RECON_ERR_EN
      r_x1  <= '0;
      r_x2  <= '0;
      r_e1  <= '0;
      r_e2  <= '0;
`endif
    end else begin
      case (r_state)
        IDLE: if (in_valid) begin
          r_y1  <= y1_in;
          r_y2  <= y2_in;
          r_w11 <= w11_in;
          r_w12 <= w12_in;
          r_w21 <= w21_in;
          r_w22 <= w22_in;
`ifdef PCA_RECON_ERR_EN
          r_x1  <= x1_in;
          r_x2  <= x2_in;
`endif
        end
        MUL1: r_acc <= w_term;
        MUL2: r_p1  <= r_acc + w_term;
        MUL3: r_acc <= w_term;
        MUL4: begin
          r_xh1 <= r_p1;
          r_xh2 <= r_acc + w_term;
`ifdef PCA_RECON_ERR_EN
          r_e1  <= r_x1 - r_p1;
          r_e2  <= r_x2 - (r_acc + w_term);
`endif
        end
        default: ;
      endcase
    end

  assign xh1_out = r_xh1;
  assign xh2_out = r_xh2;
`ifdef PCA_RECON_ERR_EN
  assign e1_out  = r_e1;
  assign e2_out  = r_e2;
`endif

endmodule

// File: tb/tb_pca_recon.sv
// tb_pca_recon: scoreboard bench for pca_recon (error outputs checked when PCA_RECON_ERR_EN is defined)
module tb_pca_recon;

  localparam int FRAC = 16;

  logic        clk = 0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] y1, y2, w11, w12, w21, w22, x1, x2;
  logic [31:0] xh1_out, xh2_out, e1_out, e2_out;
  logic        out_valid;
  logic        out_ready;

  typedef struct {
    logic [31:0] xh1, xh2, e1, e2;
  } exp_t;

  exp_t sb[$];
  int   n_chk = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  pca_recon #(.FRAC(FRAC)) dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .y1_in    (y1),
    .y2_in    (y2),
    .w11_in   (w11),
    .w12_in   (w12),
    .w21_in   (w21),
    .w22_in   (w22),
`ifdef PCA_RECON_ERR_EN
    .x1_in    (x1),
    .x2_in    (x2),
    .e1_out   (e1_out),
    .e2_out   (e2_out),
`endif
    .xh1_out  (xh1_out),
    .xh2_out  (xh2_out),
    .out_valid(out_valid),
    .out_ready(out_ready)
  );

`ifndef PCA_RECON_ERR_EN
  assign e1_out = '0;
  assign e2_out = '0;
`endif

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] mq(input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa, sb2, p;
    sa  = {{32{a[31]}}, a};
    sb2 = {{32{b[31]}}, b};
    p   = sa * sb2;
    return p[FRAC+31 -: 32];
  endfunction

  // Present one vector, optionally record its expected result, then scramble inputs after acceptance
  task automatic send(input logic [31:0] a1, a2, b11, b12, b21, b22, c1, c2, input bit push,
                      output logic [31:0] ex1, output logic [31:0] ex2);
    exp_t e;
    for (int i = 0; i < 50 && !in_ready; i++) @(posedge clk) #1;
    if (!in_ready) chk("rdy_timeout", {31'd0, in_ready}, 32'd1);
    y1 = a1; y2 = a2; w11 = b11; w12 = b12; w21 = b21; w22 = b22; x1 = c1; x2 = c2;
    in_valid = 1;
    e.xh1 = mq(b11, a1) + mq(b21, a2);
    e.xh2 = mq(b12, a1) + mq(b22, a2);
    e.e1  = c1 - e.xh1;
    e.e2  = c2 - e.xh2;
    ex1 = e.xh1;
    ex2 = e.xh2;
    if (push) sb.push_back(e);
    @(posedge clk) #1;
    in_valid = 0;
    y1 = $urandom; y2 = $urandom; w11 = $urandom; w12 = $urandom;
    w21 = $urandom; w22 = $urandom; x1 = $urandom; x2 = $urandom;
  endtask

  task automatic wait_ov(output int lat);
    lat = 0;
    for (int i = 0; i < 50 && !out_valid; i++) begin
      @(posedge clk) #1;
      lat++;
    end
    if (!out_valid) chk("ov_timeout", {31'd0, out_valid}, 32'd1);
  endtask

  // Scoreboard: compare each result on the cycle it is handed off
  always @(negedge clk)
    if (!reset && out_valid && out_ready) begin
      if (sb.size() == 0) chk("sb_empty", sb.size(), 32'd1);
      else begin
        exp_t e;
        e = sb.pop_front();
        chk("xh1", xh1_out, e.xh1);
        chk("xh2", xh2_out, e.xh2);
`ifdef PCA_RECON_ERR_EN
        chk("e1", e1_out, e.e1);
        chk("e2", e2_out, e.e2);
`endif
      end
    end

  initial begin
    logic [31:0] ex1, ex2;
    int lat, cnt;
    reset = 1; in_valid = 0; out_ready = 1;
    {y1, y2, w11, w12, w21, w22, x1, x2} = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_xh1", xh1_out, 32'd0);
    chk("rst_xh2", xh2_out, 32'd0);
    chk("rst_e1", e1_out, 32'd0);
    reset = 0;
    @(posedge clk) #1;
    chk("rel_in_ready", {31'd0, in_ready}, 32'd1);

    // Identity with latency check
    send(32'h0002_0000, 32'h0003_0000, 32'h0001_0000, 0, 0, 32'h0001_0000,
         32'h0002_8000, 32'h0003_0000, 1, ex1, ex2);
    chk("busy_in_ready", {31'd0, in_ready}, 32'd0);
    wait_ov(lat);
    chk("latency", lat, 32'd4);
    chk("id_xh1_const", ex1, 32'h0002_0000);
    // All-half and negative cases
    send(32'h0001_0000, 32'h0001_0000, 32'h0000_8000, 32'h0000_8000, 32'h0000_8000, 32'h0000_8000,
         0, 0, 1, ex1, ex2);
    chk("half_xh_const", ex1, 32'h0001_0000);
    send(32'h0001_0000, 0, 32'hFFFF_0000, 0, 0, 0, 32'h1234_5678, 0, 1, ex1, ex2);
    chk("neg_xh1_const", ex1, 32'hFFFF_0000);
    // Random vectors, including full-range operands that wrap
    for (int i = 0; i < 6; i++)
      send($urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, 1, ex1, ex2);

    // Backpressure
    for (int i = 0; i < 50 && !in_ready; i++) @(posedge clk) #1;
    out_ready = 0;
    send(32'h0003_4000, 32'hFFFE_8000, 32'h0001_2000, 32'hFFFF_C000, 32'h0000_6000, 32'h0002_0000,
         32'h0000_1000, 32'h0000_2000, 1, ex1, ex2);
    wait_ov(lat);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk) #1;
      chk("bp_out_valid", {31'd0, out_valid}, 32'd1);
      chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
      chk("bp_xh1", xh1_out, ex1);
      chk("bp_xh2", xh2_out, ex2);
    end
    out_ready = 1;
    @(posedge clk) #1;
    chk("bp_rel_in_ready", {31'd0, in_ready}, 32'd1);
    chk("bp_rel_out_valid", {31'd0, out_valid}, 32'd0);
    chk("hold_xh1", xh1_out, ex1);
    chk("hold_xh2", xh2_out, ex2);

    // Reset during MUL2 discards the result
    send(32'h0005_0000, 32'h0007_0000, 32'h0001_0000, 32'h0002_0000, 32'h0003_0000, 32'h0004_0000,
         0, 0, 0, ex1, ex2);
    @(posedge clk) #1;
    reset = 1;
    #1;
    chk("mr_xh1", xh1_out, 32'd0);
    chk("mr_xh2", xh2_out, 32'd0);
    chk("mr_in_ready", {31'd0, in_ready}, 32'd0);
    @(posedge clk) #1;
    reset = 0;
    @(posedge clk) #1;
    chk("mr_rel_in_ready", {31'd0, in_ready}, 32'd1);
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      if (out_valid) cnt++;
      @(posedge clk) #1;
    end
    chk("mr_no_out_valid", cnt, 32'd0);
    send(32'h0005_0000, 32'h0007_0000, 32'h0001_0000, 32'h0002_0000, 32'h0003_0000, 32'h0004_0000,
         32'h0020_0000, 32'h0030_0000, 1, ex1, ex2);
    chk("post_xh1_const", ex1, 32'h001A_0000);

    for (int i = 0; i < 50 && sb.size() != 0; i++) @(posedge clk) #1;
    chk("sb_drained", sb.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
